// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pkg
//  Description : Shared defaults, state encoding and bit-reversal helper for
//                the FFT reorder controller.
//  Revision    : 1.0
// ============================================================================
package fft_pkg;

    localparam int FFT_WORDSIZE = 16;
    localparam int FFT_ADDRSIZE = 8;
    localparam int FFT_NUMADDR  = 64;
    localparam int FFT_LOGN     = 6;

    typedef enum logic [0:0] {
        ST_WRITE = 1'b0,
        ST_READ  = 1'b1
    } state_e;

    // Reverses the low 'width' bits of v; bits above width come back zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < int'(width)) begin
                r = {r[30:0], v[i]};
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bitrev_ram_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : bitrev_ram_ctrl_if
//  Description : Sample stream in/out plus RAM port bundle of the reorder
//                controller. master = controller, slave = its surroundings.
//  Revision    : 1.0
// ============================================================================
interface bitrev_ram_ctrl_if
    import fft_pkg::*;
#(
    parameter int WORDSIZE = FFT_WORDSIZE,
    parameter int ADDRSIZE = FFT_ADDRSIZE
);
    logic                in_valid;
    logic                in_ready;
    logic [WORDSIZE-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [WORDSIZE-1:0] out_data;
    logic                frame_done;
    logic [ADDRSIZE-1:0] ram_read_addr;
    logic [ADDRSIZE-1:0] ram_write_addr;
    logic                ram_rd_en;
    logic                ram_wr_en;
    logic                ram_cs;
    logic [WORDSIZE-1:0] ram_data_in;
    logic [WORDSIZE-1:0] ram_data_out;

    modport master (
        input  in_valid, in_data, out_ready, ram_data_out,
        output in_ready, out_valid, out_data, frame_done,
               ram_read_addr, ram_write_addr, ram_rd_en, ram_wr_en, ram_cs, ram_data_in
    );

    modport slave (
        output in_valid, in_data, out_ready, ram_data_out,
        input  in_ready, out_valid, out_data, frame_done,
               ram_read_addr, ram_write_addr, ram_rd_en, ram_wr_en, ram_cs, ram_data_in
    );

endinterface
`default_nettype wire

// File: rtl/bitrev_ram_ctrl_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : skid_fifo2
//  Description : Two-entry output FIFO with registered head; absorbs the RAM
//                read latency so the output stream has no bubbles.
//  Revision    : 1.0
// ============================================================================
module skid_fifo2 #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] push_data_i,
    input  wire logic             pop_i,
    output logic                  valid_o,
    output logic [WIDTH-1:0]      data_o,
    output logic [1:0]            occ_o
);
    logic [WIDTH-1:0] mem_q [2];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [1:0]       occ_q;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop_i & (occ_q != 2'd0);
    assign do_push = push_i & ((occ_q != 2'd2) | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign valid_o = (occ_q != 2'd0);
    assign data_o  = mem_q[rd_ptr_q];
    assign occ_o   = occ_q;

endmodule
`default_nettype wire

// File: rtl/bitrev_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bitrev_ram_ctrl
//  Description : Half-duplex reorder controller: writes a frame at bit-reversed
//                addresses, then streams it back out in natural order.
//  Revision    : 1.0
// ============================================================================
module bitrev_ram_ctrl
    import fft_pkg::*;
#(
    parameter int WORDSIZE = FFT_WORDSIZE,
    parameter int ADDRSIZE = FFT_ADDRSIZE,
    parameter int NUMADDR  = FFT_NUMADDR,
    parameter int LOGN     = FFT_LOGN
) (
    input  wire logic           clk,
    input  wire logic           rst,
    bitrev_ram_ctrl_if.master   bus
);
    localparam logic [LOGN:0] CNT_FULL = (LOGN+1)'(NUMADDR);
    localparam logic [LOGN:0] CNT_LAST = (LOGN+1)'(NUMADDR - 1);

    state_e        state_q, state_d;
    logic [LOGN:0] wr_cnt_q, wr_cnt_d;
    logic [LOGN:0] rd_cnt_q, rd_cnt_d;
    logic [LOGN:0] pop_cnt_q, pop_cnt_d;
    logic          inflight_q, inflight_d;

    logic          in_ready;
    logic          wr_en;
    logic          rd_en;
    logic          frame_done;
    logic          pop;
    logic          issue;
    logic          fifo_valid;
    logic [1:0]    fifo_occ;
    logic [2:0]    pending;

    assign pop     = fifo_valid & bus.out_ready;
    assign pending = {1'b0, fifo_occ} + {2'b0, inflight_q};
    // Budget counts the slot freed by this cycle's pop, so steady state streams at full rate.
    assign issue   = (rd_cnt_q != CNT_FULL) && (pending < (3'd2 + {2'b0, pop}));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_WRITE;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            pop_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
            inflight_q <= inflight_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        pop_cnt_d  = pop_cnt_q;
        inflight_d = 1'b0;
        in_ready   = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            ST_WRITE: begin
                in_ready = 1'b1;
                wr_en    = bus.in_valid;
                if (wr_en) begin
                    if (wr_cnt_q == CNT_LAST) begin
                        state_d  = ST_READ;
                        wr_cnt_d = '0;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            ST_READ: begin
                rd_en      = issue;
                inflight_d = issue;
                if (issue) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
                if (pop) begin
                    if (pop_cnt_q == CNT_LAST) begin
                        frame_done = 1'b1;
                        state_d    = ST_WRITE;
                        wr_cnt_d   = '0;
                        rd_cnt_d   = '0;
                        pop_cnt_d  = '0;
                    end else begin
                        pop_cnt_d = pop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_WRITE;
        endcase
    end

    skid_fifo2 #(
        .WIDTH (WORDSIZE)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i (bus.ram_data_out),
        .pop_i       (pop),
        .valid_o     (fifo_valid),
        .data_o      (bus.out_data),
        .occ_o       (fifo_occ)
    );

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = fifo_valid;
    assign bus.frame_done     = frame_done;
    assign bus.ram_wr_en      = wr_en;
    assign bus.ram_rd_en      = rd_en;
    assign bus.ram_cs         = rd_en | wr_en;
    assign bus.ram_data_in    = bus.in_data;
    assign bus.ram_write_addr = ADDRSIZE'(bitrev(32'(wr_cnt_q[LOGN-1:0]), LOGN));
    assign bus.ram_read_addr  = ADDRSIZE'(rd_cnt_q);

endmodule
`default_nettype wire

// File: tb/tb_bitrev_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bitrev_ram_ctrl
//  Description : Directed self-checking bench for bitrev_ram_ctrl with a
//                behavioural one-cycle-latency RAM.
//  Revision    : 1.0
// ============================================================================
module tb_bitrev_ram_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    bitrev_ram_ctrl_if #(.WORDSIZE(16), .ADDRSIZE(8)) bus ();

    bitrev_ram_ctrl #(
        .WORDSIZE (16),
        .ADDRSIZE (8),
        .NUMADDR  (64),
        .LOGN     (6)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] ram_mem [256];
    logic [15:0] ram_rdata;

    always @(posedge clk) begin
        if (bus.ram_cs && bus.ram_wr_en) ram_mem[bus.ram_write_addr] <= bus.ram_data_in;
        if (bus.ram_cs && bus.ram_rd_en) ram_rdata <= ram_mem[bus.ram_read_addr];
    end
    assign bus.ram_data_out = ram_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int rev6(input int v);
        int r;
        r = 0;
        for (int b = 0; b < 6; b++) if ((v & (1 << b)) != 0) r = r | (1 << (5 - b));
        return r;
    endfunction

    function automatic logic [15:0] sample(input int pat, input int k);
        case (pat)
            0:       return 16'hFFFF - 16'(k);
            1:       return 16'h1234 + 16'(k * 3);
            2:       return 16'hA5A5 ^ 16'(k << 4);
            default: return 16'(k * 257) + 16'h0F00;
        endcase
    endfunction

    // One sample offered every 'gap' cycles until 64 have been accepted.
    task automatic fill(input int pat, input int gap);
        int k;
        int cyc;
        k   = 0;
        cyc = 0;
        while (k < 64 && cyc < 64 * gap + 16) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            bus.in_valid  = ((cyc % gap) == 0);
            bus.in_data   = bus.in_valid ? sample(pat, k) : 16'hDEAD;
            #1;
            chk("fill_in_ready", 32'(bus.in_ready), 32'd1);
            chk("fill_wr_en", 32'(bus.ram_wr_en), 32'(bus.in_valid));
            chk("fill_cs", 32'(bus.ram_cs), 32'(bus.in_valid));
            chk("fill_rd_en", 32'(bus.ram_rd_en), 32'd0);
            if (bus.in_valid) begin
                chk("fill_waddr", 32'(bus.ram_write_addr), 32'(rev6(k)));
                chk("fill_wdata", 32'(bus.ram_data_in), 32'(sample(pat, k)));
                k++;
            end
            cyc++;
        end
        if (k < 64) chk("fill_timeout", 32'(k), 32'd64);
    endtask

    // Pops up to stop_after samples; toggle selects the 1,0,0,1 out_ready pattern.
    task automatic drain(input int pat, input bit toggle, input int stop_after);
        int          j;
        int          cyc;
        int          issued;
        int          first_valid;
        int          first_rd;
        bit          hold;
        bit          pop;
        logic [15:0] held;
        logic [3:0]  rp;
        j           = 0;
        cyc         = 0;
        issued      = 0;
        first_valid = -1;
        first_rd    = -1;
        hold        = 1'b0;
        held        = '0;
        rp          = 4'b1001;
        while (j < stop_after && cyc < 400) begin
            @(negedge clk);
            bus.in_valid  = 1'b0;
            bus.out_ready = toggle ? rp[cyc % 4] : 1'b1;
            #1;
            pop = bus.out_valid && bus.out_ready;
            if (bus.out_valid && first_valid < 0) first_valid = cyc;
            chk("rd_in_ready", 32'(bus.in_ready), 32'd0);
            chk("rd_wr_en", 32'(bus.ram_wr_en), 32'd0);
            chk("rd_cs", 32'(bus.ram_cs), 32'(bus.ram_rd_en));
            if (hold && bus.out_valid) chk("hold_stable", 32'(bus.out_data), 32'(held));
            if (bus.ram_rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                chk("rd_addr", 32'(bus.ram_read_addr), 32'(issued));
                chk("rd_budget", 32'((issued - j - int'(pop)) < 2), 32'd1);
                chk("rd_overissue", 32'(issued < 64), 32'd1);
                issued++;
            end
            if (pop) begin
                chk("out_data", 32'(bus.out_data), 32'(sample(pat, rev6(j))));
                chk("frame_done_pop", 32'(bus.frame_done), 32'(j == 63));
                j++;
            end else begin
                chk("frame_done_idle", 32'(bus.frame_done), 32'd0);
            end
            hold = bus.out_valid && !bus.out_ready;
            held = bus.out_data;
            cyc++;
        end
        if (j < stop_after) chk("drain_timeout", 32'(j), 32'(stop_after));
        chk("first_rd_cycle", 32'(first_rd), 32'd0);
        chk("first_valid_cycle", 32'(first_valid), 32'd2);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
        chk("rst_rd_en", 32'(bus.ram_rd_en), 32'd0);
        chk("rst_wr_en", 32'(bus.ram_wr_en), 32'd0);
        chk("rst_cs", 32'(bus.ram_cs), 32'd0);
        chk("rst_raddr", 32'(bus.ram_read_addr), 32'd0);
        chk("rst_waddr", 32'(bus.ram_write_addr), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        fill(0, 1);
        drain(0, 1'b0, 64);

        fill(1, 3);
        drain(1, 1'b1, 64);

        fill(2, 1);
        drain(2, 1'b0, 20);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_rd_en", 32'(bus.ram_rd_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_rst_waddr", 32'(bus.ram_write_addr), 32'd0);

        fill(3, 1);
        drain(3, 1'b0, 64);
        fill(2, 1);
        drain(2, 1'b0, 64);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
